lif_array: RTL and testbench
============================

LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter N_CH, default 4, number of independent LIF neuron channels (1..16).
REQ-002 Parameter W, default 8, membrane-state and input-current width in bits (4..16).
REQ-003 Parameter LEAK_SHIFT, default 1, leak term is state >> LEAK_SHIFT (1..W-1).
REQ-004 Parameter RESET_MODE, default 0: 0 = state to zero on spike, 1 = subtract threshold on spike.
REQ-005 Parameter REFRAC_CYC, default 2, refractory length in enabled cycles (0..15).
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset_n  input  1  reset, synchronous and active-low.
REQ-008 en  input  1  global update enable.
REQ-009 current  input  N_CH*W  per-channel unsigned input current; channel i is bits [i*W +: W].
REQ-010 threshold  input  W  shared unsigned firing threshold; 0 disables firing.
REQ-011 clr_cnt  input  1  synchronous clear of spike_count.
REQ-012 state  output  N_CH*W  per-channel membrane state, registered, same packing as current.
REQ-013 spike  output  N_CH  per-channel spike flag, registered, high for one cycle per firing.
REQ-014 spike_any  output  1  registered OR of spike.
REQ-015 spike_count  output  16  saturating total count of spikes across all channels.

Function
REQ-016 Per channel, on each edge with en=1 and not refractory, compute v = state - (state >> LEAK_SHIFT) + current_i in W+1 bits; v_sat = min(v, 2^W-1).
REQ-017 If threshold != 0 and v_sat >= threshold: spike_i <= 1; state_i <= 0 (RESET_MODE=0) or v_sat - threshold (RESET_MODE=1); refractory counter loads REFRAC_CYC.
REQ-018 Otherwise state_i <= v_sat and spike_i <= 0.
REQ-019 Latency: a current applied before edge k affects state and spike registered at edge k; no combinational input-to-output path.
REQ-020 Refractory (counter nonzero, en=1): state_i <= 0, spike_i <= 0, current ignored, counter decrements by 1.
REQ-021 Firing with REFRAC_CYC=0 loads no refractory period; the channel may fire on consecutive edges.
REQ-022 en=0: state, refractory counters and spike_count hold; spike and spike_any <= 0.
REQ-023 spike_any <= OR of the next-cycle spike values, so it is coincident with spike.
REQ-024 spike_count <= min(spike_count + popcount(next spike vector), 65535) on each edge.
REQ-025 clr_cnt=1 has priority: spike_count <= popcount of that edge's spike vector.
REQ-026 Channels are fully independent; a threshold change takes effect at the next edge for all channels.

Reset
REQ-027 reset_n=0 at an edge: all state=0, spike=0, spike_any=0, spike_count=0, refractory counters=0.
REQ-028 Reset overrides en and clr_cnt and aborts any refractory period in progress.

Configuration
REQ-029 Macro LIF_REFRACTORY_EN defined: refractory counters and REQ-020 behaviour are present.
REQ-030 LIF_REFRACTORY_EN undefined: no refractory hardware; REFRAC_CYC is ignored; behaviour equals REFRAC_CYC=0.

Verification
REQ-031 Defaults, macro defined, threshold=200, ch0 current=120 constant, en=1: ch0 state 120, 180, then spike=1 with state=0 at edge 3; edges 4-5 state=0, spike=0; edge 6 state=120.
REQ-032 Same stimulus, macro undefined: spike at edge 3, state=120 at edge 4, no refractory gap.
REQ-033 RESET_MODE=1, threshold=200, current=120: edge 3 spike=1, state=10.
REQ-034 threshold=0, current=255: state 255 at edge 1 and saturates at 255 thereafter, spike never asserted.
REQ-035 en dropped after edge 2 of REQ-031 for 3 cycles: state holds 180, spike=0; re-enable gives the spike at the next edge.
REQ-036 All 4 channels at current=255, threshold=1, spike_count preset near 65534: saturates at 65535; clr_cnt with 4 simultaneous spikes gives 4; reset_n low mid-refractory clears all outputs to 0 at that edge.

Source files
------------

// File: rtl/lif_array.sv
`default_nettype none
// ============================================================================
// Module      : lif_array
// Description : Array of N_CH independent leaky integrate-and-fire neurons
//               sharing one threshold, with registered state/spike outputs
//               and a saturating 16-bit total spike counter.
//               Optional feature macro: LIF_REFRACTORY_EN adds per-channel
//               refractory counters of REFRAC_CYC enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_array #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int RESET_MODE = 0,
    parameter int REFRAC_CYC = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [N_CH*W-1:0]   current,
    input  logic [W-1:0]        threshold,
    input  logic                clr_cnt,
    output logic [N_CH*W-1:0]   state,
    output logic [N_CH-1:0]     spike,
    output logic                spike_any,
    output logic [15:0]         spike_count
);

    // Elaboration-time parameter range checks
    if (N_CH < 1 || N_CH > 16) begin : g_chk_n_ch
        $error("lif_array: N_CH out of range");
    end
    if (W < 4 || W > 16) begin : g_chk_w
        $error("lif_array: W out of range");
    end
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > W - 1) begin : g_chk_leak
        $error("lif_array: LEAK_SHIFT out of range");
    end
    if (RESET_MODE < 0 || RESET_MODE > 1) begin : g_chk_mode
        $error("lif_array: RESET_MODE out of range");
    end
    if (REFRAC_CYC < 0 || REFRAC_CYC > 15) begin : g_chk_refrac
        $error("lif_array: REFRAC_CYC out of range");
    end

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [N_CH*W-1:0] r_state;
    logic [N_CH-1:0]   r_spike;
    logic              r_spike_any;
    logic [15:0]       r_spike_count;

    logic [N_CH*W-1:0] w_state_nxt;
    logic [N_CH-1:0]   w_spike_nxt;
    logic [4:0]        w_pop;
    logic [16:0]       w_cnt_sum;
    logic [15:0]       w_cnt_nxt;

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            logic [W-1:0] w_cur;
            logic [W-1:0] w_st;
            logic [W:0]   w_v;
            logic [W-1:0] w_vsat;
            logic         w_fire;
            logic [W-1:0] w_fire_val;
            logic         w_refrac;

            assign w_cur  = current[i*W +: W];
            assign w_st   = r_state[i*W +: W];
            // state - leak never underflows, and the sum fits in W+1 bits
            assign w_v    = {1'b0, w_st} - {1'b0, (w_st >> LEAK_SHIFT)} + {1'b0, w_cur};
            assign w_vsat = w_v[W] ? {W{1'b1}} : w_v[W-1:0];
            assign w_fire = (threshold != '0) && (w_vsat >= threshold);

            if (RESET_MODE == 1) begin : g_sub_thr
                assign w_fire_val = w_vsat - threshold;
            end else begin : g_to_zero
                assign w_fire_val = '0;
            end

`ifdef LIF_REFRACTORY_EN
            localparam logic [3:0] c_refrac = 4'(REFRAC_CYC);
            logic [3:0] r_refrac;

            assign w_refrac = (r_refrac != 4'd0);

            // Refractory counter: load on firing, count down while enabled
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_refrac <= 4'd0;
                end else if (en) begin
                    if (w_refrac) begin
                        r_refrac <= r_refrac - 4'd1;
                    end else if (w_fire) begin
                        r_refrac <= c_refrac;
                    end
                end
            end
`else
            assign w_refrac = 1'b0;
`endif

            // Next membrane state: hold when disabled, zero while refractory
            assign w_state_nxt[i*W +: W] = !en      ? w_st       :
                                           w_refrac ? '0         :
                                           w_fire   ? w_fire_val : w_vsat;
            assign w_spike_nxt[i] = en && !w_refrac && w_fire;
        end
    endgenerate

    // Population count of the spike vector about to be registered
    always_comb begin
        w_pop = 5'd0;
        for (int k = 0; k < N_CH; k++) begin
            w_pop = w_pop + 5'(w_spike_nxt[k]);
        end
    end

    assign w_cnt_sum = {1'b0, r_spike_count} + 17'(w_pop);
    assign w_cnt_nxt = clr_cnt      ? 16'(w_pop) :
                       w_cnt_sum[16] ? c_cnt_max  : w_cnt_sum[15:0];

    // Output registers: state, spikes, spike OR and saturating counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= '0;
            r_spike       <= '0;
            r_spike_any   <= 1'b0;
            r_spike_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_spike       <= w_spike_nxt;
            r_spike_any   <= |w_spike_nxt;
            r_spike_count <= w_cnt_nxt;
        end
    end

    assign state       = r_state;
    assign spike       = r_spike;
    assign spike_any   = r_spike_any;
    assign spike_count = r_spike_count;

endmodule
`default_nettype wire

// File: tb/tb_lif_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_array
// Description : Directed self-checking bench for lif_array (default params
//               plus a RESET_MODE=1 instance driven by the same inputs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_array;

`ifdef LIF_REFRACTORY_EN
    localparam bit c_refrac = 1'b1;
    localparam int c_period = 3;
`else
    localparam bit c_refrac = 1'b0;
    localparam int c_period = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] current = '0;
    logic [7:0]  threshold = '0;
    logic        clr_cnt = 1'b0;

    logic [31:0] state;
    logic [3:0]  spike;
    logic        spike_any;
    logic [15:0] spike_count;

    logic [31:0] state_rm;
    logic [3:0]  spike_rm;
    logic        spike_any_rm;
    logic [15:0] spike_count_rm;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lif_array dut (
        .clk(clk), .reset_n(reset_n), .en(en), .current(current),
        .threshold(threshold), .clr_cnt(clr_cnt), .state(state),
        .spike(spike), .spike_any(spike_any), .spike_count(spike_count)
    );

    lif_array #(.RESET_MODE(1)) dut_rm (
        .clk(clk), .reset_n(reset_n), .en(en), .current(current),
        .threshold(threshold), .clr_cnt(clr_cnt), .state(state_rm),
        .spike(spike_rm), .spike_any(spike_any_rm), .spike_count(spike_count_rm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; en = 1'b0; clr_cnt = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; clr_cnt = 1'b1;
        current = 32'hFFFF_FFFF; threshold = 8'd1;
        tick();
        n_total++;
        if ({state, spike, spike_any, spike_count} !== '0)
            $display("FAIL reset_outputs: got state=%h spike=%b any=%b cnt=%0d, want all 0",
                     state, spike, spike_any, spike_count);
        else n_pass++;
        reset_n = 1'b1; clr_cnt = 1'b0;
    endtask

    task automatic test_integrate_fire();
        logic [7:0] exp_st0 [6];
        logic       exp_sp0 [6];
        logic [7:0] exp_st1 [6];
        exp_st1 = '{8'd50, 8'd75, 8'd88, 8'd94, 8'd97, 8'd99};
        if (c_refrac) begin
            exp_st0 = '{8'd120, 8'd180, 8'd0, 8'd0, 8'd0, 8'd120};
            exp_sp0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        end else begin
            exp_st0 = '{8'd120, 8'd180, 8'd0, 8'd120, 8'd180, 8'd0};
            exp_sp0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        end
        do_reset();
        threshold = 8'd200;
        current   = {8'd0, 8'd0, 8'd50, 8'd120};
        en        = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            n_total++;
            if (state[7:0] !== exp_st0[e] || spike[0] !== exp_sp0[e] || spike_any !== exp_sp0[e])
                $display("FAIL fire_ch0_edge%0d: got state=%0d spike=%b any=%b, want state=%0d spike=%b",
                         e + 1, state[7:0], spike[0], spike_any, exp_st0[e], exp_sp0[e]);
            else n_pass++;
            n_total++;
            if (state[15:8] !== exp_st1[e] || state[31:16] !== 16'd0 || spike[3:1] !== 3'b000)
                $display("FAIL indep_ch1_edge%0d: got state=%h spike=%b, want ch1=%0d others 0",
                         e + 1, state, spike, exp_st1[e]);
            else n_pass++;
            if (e == 2) begin
                n_total++;
                if (state_rm[7:0] !== 8'd10 || spike_rm[0] !== 1'b1)
                    $display("FAIL subtract_mode_edge3: got state=%0d spike=%b, want state=10 spike=1",
                             state_rm[7:0], spike_rm[0]);
                else n_pass++;
            end
        end
        n_total++;
        if (spike_count !== (c_refrac ? 16'd1 : 16'd2))
            $display("FAIL fire_count: got %0d, want %0d", spike_count, c_refrac ? 1 : 2);
        else n_pass++;
    endtask

    task automatic test_no_threshold();
        do_reset();
        threshold = 8'd0;
        current   = 32'hFFFF_FFFF;
        en        = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            n_total++;
            if (state !== 32'hFFFF_FFFF || spike !== 4'b0000 || spike_any !== 1'b0)
                $display("FAIL sat_no_fire_edge%0d: got state=%h spike=%b any=%b, want state=ffffffff spike=0",
                         e + 1, state, spike, spike_any);
            else n_pass++;
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        threshold = 8'd200;
        current   = {8'd0, 8'd0, 8'd0, 8'd120};
        en        = 1'b1;
        tick();
        tick();
        en = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_total++;
            if (state[7:0] !== 8'd180 || spike[0] !== 1'b0 || spike_any !== 1'b0)
                $display("FAIL en_hold_cycle%0d: got state=%0d spike=%b, want state=180 spike=0",
                         e + 1, state[7:0], spike[0]);
            else n_pass++;
        end
        en = 1'b1;
        tick();
        n_total++;
        if (state[7:0] !== 8'd0 || spike[0] !== 1'b1 || spike_count !== 16'd1)
            $display("FAIL en_resume: got state=%0d spike=%b cnt=%0d, want state=0 spike=1 cnt=1",
                     state[7:0], spike[0], spike_count);
        else n_pass++;
    endtask

    task automatic test_count_saturation();
        do_reset();
        threshold = 8'd1;
        current   = 32'hFFFF_FFFF;
        en        = 1'b1;
        tick();
        for (int k = 2; k <= 16383; k++) repeat (c_period) tick();
        n_total++;
        if (spike_count !== 16'd65532 || spike !== 4'b1111)
            $display("FAIL cnt_pre_sat: got cnt=%0d spike=%b, want cnt=65532 spike=1111",
                     spike_count, spike);
        else n_pass++;
        repeat (c_period) tick();
        n_total++;
        if (spike_count !== 16'd65535)
            $display("FAIL cnt_saturate: got %0d, want 65535", spike_count);
        else n_pass++;
        repeat (c_period) tick();
        n_total++;
        if (spike_count !== 16'd65535)
            $display("FAIL cnt_stay_sat: got %0d, want 65535", spike_count);
        else n_pass++;
        repeat (c_period - 1) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_total++;
        if (spike_count !== 16'd4 || spike !== 4'b1111)
            $display("FAIL clr_with_4_spikes: got cnt=%0d spike=%b, want cnt=4 spike=1111",
                     spike_count, spike);
        else n_pass++;
        // next edge lies inside the refractory window when that feature exists
        reset_n = 1'b0;
        tick();
        n_total++;
        if ({state, spike, spike_any, spike_count} !== '0)
            $display("FAIL reset_mid_refrac: got state=%h spike=%b any=%b cnt=%0d, want all 0",
                     state, spike, spike_any, spike_count);
        else n_pass++;
        reset_n = 1'b1;
        tick();
        n_total++;
        if (spike !== 4'b1111 || spike_count !== 16'd4)
            $display("FAIL refrac_aborted: got spike=%b cnt=%0d, want spike=1111 cnt=4",
                     spike, spike_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_integrate_fire();
        test_no_threshold();
        test_enable_hold();
        test_count_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
